pipelined_cla_adder: RTL and testbench

- Parametrised two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Generalises the fixed 32-bit, 4-block carry generator to any WIDTH and BLOCK size.
- Adds subtract mode, status flags and valid/ready flow control so the ALU can stall without losing operations.

---
 rtl/cla_pkg.sv | 45 ++++
 rtl/cla_gp_block.sv | 25 ++
 rtl/pipelined_cla_adder.sv | 169 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared carry-lookahead constants and the block-carry equations
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

   localparam int CLA_WIDTH    = 32;
   localparam int CLA_BLOCK    = 8;
   localparam int CLA_MAX_NBLK = 32;

   // Flat sum-of-products: c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]cin.
   // No term depends on another block's carry, so there is no inter-block ripple.
   function automatic logic [CLA_MAX_NBLK:0] block_carries(
      input logic [CLA_MAX_NBLK-1:0] gblk,
      input logic [CLA_MAX_NBLK-1:0] pblk,
      input logic                    cin,
      input int                      nblk
   );
      logic [CLA_MAX_NBLK:0] c;
      logic                  term;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < CLA_MAX_NBLK; i++) begin
         if (i < nblk) begin
            term = cin;
            for (int k = 0; k <= i; k++) begin
               term = term & pblk[k];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
               term = gblk[j];
               for (int k = j + 1; k <= i; k++) begin
                  term = term & pblk[k];
               end
               c[i+1] = c[i+1] | term;
            end
         end
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_gp_block.sv
`default_nettype none
// ============================================================================
//  Module      : cla_gp_block
//  Description : Reduces one block of bit generate/propagate into block G and P
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_gp_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] g,
   input  logic [BLOCK-1:0] p,
   output logic             gblk,
   output logic             pblk
);

   always_comb begin
      gblk = 1'b0;
      for (int k = 0; k < BLOCK; k++) begin
         gblk = g[k] | (p[k] & gblk);
      end
      pblk = &p;
   end

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : Two-stage carry-lookahead add/subtract with flags and
//                valid/ready flow control. Define CLA_SAT_EN for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int BLOCK = CLA_BLOCK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
`ifdef CLA_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NBLK = WIDTH / BLOCK;

   logic             w_s2_adv;
   logic             w_accept;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;
   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [NBLK-1:0]  w_gblk;
   logic [NBLK-1:0]  w_pblk;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s1_cin;
   logic [NBLK-1:0]  r_s1_gblk;
   logic [NBLK-1:0]  r_s1_pblk;
`ifdef CLA_SAT_EN
   logic             r_s1_sat;
`endif

   logic [CLA_MAX_NBLK:0] w_cblk_all;
   logic [NBLK:0]         w_cblk;
   logic [WIDTH-1:0]      w_g2;
   logic [WIDTH-1:0]      w_p2;
   logic [WIDTH-1:0]      w_carry;
   logic [WIDTH-1:0]      w_sum;
   logic [WIDTH-1:0]      w_res;
   logic                  w_cout;
   logic                  w_ovf;

   // in_ready is a function of pipeline state only, never of in_valid.
   assign w_s2_adv = ~out_valid | out_ready;
   assign in_ready = ~r_s1_valid | w_s2_adv;
   assign w_accept = in_valid & in_ready;

   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub | cin;
   assign w_g       = a & w_b_eff;
   assign w_p       = a | w_b_eff;

   for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      cla_gp_block #(
         .BLOCK (BLOCK)
      ) u_gp (
         .g    (w_g[gi*BLOCK +: BLOCK]),
         .p    (w_p[gi*BLOCK +: BLOCK]),
         .gblk (w_gblk[gi]),
         .pblk (w_pblk[gi])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_cin   <= 1'b0;
         r_s1_gblk  <= '0;
         r_s1_pblk  <= '0;
`ifdef CLA_SAT_EN
         r_s1_sat   <= 1'b0;
`endif
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a    <= a;
            r_s1_b    <= w_b_eff;
            r_s1_cin  <= w_cin_eff;
            r_s1_gblk <= w_gblk;
            r_s1_pblk <= w_pblk;
`ifdef CLA_SAT_EN
            r_s1_sat  <= sat;
`endif
         end
      end
   end

   assign w_cblk_all = block_carries(CLA_MAX_NBLK'(r_s1_gblk), CLA_MAX_NBLK'(r_s1_pblk),
                                     r_s1_cin, NBLK);
   assign w_cblk     = w_cblk_all[NBLK:0];

   if (NBLK < CLA_MAX_NBLK) begin : g_spare
      logic unused_cblk;
      assign unused_cblk = ^w_cblk_all[CLA_MAX_NBLK:NBLK+1];
   end

   assign w_g2 = r_s1_a & r_s1_b;
   assign w_p2 = r_s1_a | r_s1_b;

   // Within a block the carry ripples from that block's lookahead carry-in.
   always_comb begin
      logic v_c;
      w_carry = '0;
      v_c     = 1'b0;
      for (int i = 0; i < NBLK; i++) begin
         v_c = w_cblk[i];
         for (int k = 0; k < BLOCK; k++) begin
            w_carry[i*BLOCK+k] = v_c;
            v_c = w_g2[i*BLOCK+k] | (w_p2[i*BLOCK+k] & v_c);
         end
      end
   end

   assign w_sum  = r_s1_a ^ r_s1_b ^ w_carry;
   assign w_cout = w_cblk[NBLK];
   assign w_ovf  = w_carry[WIDTH-1] ^ w_cout;

`ifdef CLA_SAT_EN
   // A wrapped MSB of 1 means the true result was positive, and vice versa.
   assign w_res = (r_s1_sat & w_ovf)
                ? {~w_sum[WIDTH-1], {(WIDTH-1){w_sum[WIDTH-1]}}}
                : w_sum;
`else
   assign w_res = w_sum;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (w_s2_adv) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            sum  <= w_res;
            cout <= w_cout;
            ovf  <= w_ovf;
            zero <= ~|w_res;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_cla_adder
//  Description : Directed-vector scoreboard bench for pipelined_cla_adder
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipelined_cla_adder;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        cin;
   logic        sat_r;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_in  = 0;
   int   n_out = 0;

   always #5 clock = ~clock;

   pipelined_cla_adder dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
`ifdef CLA_SAT_EN
      .sat       (sat_r),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Driver: returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tsub,
                       input logic tcin, input logic tsat, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez);
      int waitc;
      waitc    = 0;
      a        = ta;
      b        = tb_v;
      sub      = tsub;
      cin      = tcin;
      sat_r    = tsat;
      in_valid = 1'b1;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         waitc++;
         if (waitc > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
            in_valid = 1'b0;
            return;
         end
      end
      q.push_back(exp_t'{sum: es, cout: ec, ovf: eo, zero: ez});
      n_in++;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clock);
         k++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: pending got %0d want 0", q.size());
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: pops one expectation per output beat actually taken.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got sum %0h want no beat", sum);
            end else begin
               e = q.pop_front();
               n_out++;
               check("sum",  64'(sum),  64'(e.sum));
               check("cout", 64'(cout), 64'(e.cout));
               check("ovf",  64'(ovf),  64'(e.ovf));
               check("zero", 64'(zero), 64'(e.zero));
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      cin       = 1'b0;
      sat_r     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum",       64'(sum),       64'd0);
      check("rst_flags",     64'({cout, ovf, zero}), 64'd0);
      @(posedge clock);
      #1;

      // Directed vectors, streamed back to back
      send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      send(32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      send(32'h00000007, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0);
      send(32'h00000007, 32'h00000005, 1'b1, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0);
      send(32'h0000000F, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h00000020, 1'b0, 1'b0, 1'b0);
      send(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      send(32'h12345678, 32'h87654321, 1'b0, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0);
      send(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      send(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
`endif
      drain();

      // Backpressure: two ops held, third blocked
      out_ready = 1'b0;
      send(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
      send(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
      a        = 32'd3;
      b        = 32'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("stall_in_ready",  64'(in_ready),  64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_sum",       64'(sum),       64'd2);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send(32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      check("release_valid_2nd", 64'(out_valid), 64'd1);
      check("release_sum_2nd",   64'(sum),       64'd4);
      @(negedge clock);
      check("release_valid_3rd", 64'(out_valid), 64'd1);
      check("release_sum_3rd",   64'(sum),       64'd6);
      drain();

      // Reset with both stages occupied
      out_ready = 1'b0;
      send(32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);
      send(32'd1,  32'd2,  1'b0, 1'b0, 1'b0, 32'd3,  1'b0, 1'b0, 1'b0);
      @(negedge clock);
      check("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      q.delete();
      n_in = n_in - 2;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready",  64'(in_ready),  64'd1);
      check("midrst_sum",       64'(sum),       64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("midrst_no_ghost", 64'(out_valid), 64'd0);
      end
      @(posedge clock);
      #1;
      send(32'h00000100, 32'h000000FF, 1'b0, 1'b1, 1'b0, 32'h00000200, 1'b0, 1'b0, 1'b0);
      drain();

      check("beat_count", 64'(n_out), 64'(n_in));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
